// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit for the RV32 NPC datapath. Accepts one memory op
//            from the execute stage, runs a single-outstanding valid/ready
//            transaction on the data-memory port, aligns and sign/zero-extends
//            load data and emits a one-cycle write-back pulse.
// Ports    : clk, rst (sync, active-high)
//            in_*      : op from execute stage (valid/ready handshake)
//            mem_req_* : request to data memory, mem_we/addr/wdata/wmask
//            mem_rsp_* : response / write acknowledge, mem_rdata
//            wb_*      : completion pulse to the register file
// Config   : `LSU_MISALIGN_CHECK_EN - when defined, misaligned halfword/word
//            accesses fault (wb_err) instead of being forced aligned.
// Revision : 1.0 - initial release
// ============================================================================
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_err;

    logic        w_legal;
    logic        w_err;
    logic [1:0]  w_off_eff;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_sh;
    logic [31:0] w_ld;

    // Legal funct3 depends on direction: stores only have SB/SH/SW.
    always_comb begin
        w_legal = 1'b0;
        if (in_store) begin
            w_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) ||
                      (in_funct3 == 3'b010);
        end else begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    // Effective lane offset: halfwords snap to even lanes, words to lane 0.
    // With the misalign check enabled the snapped cases never reach memory.
    always_comb begin
        case (in_funct3[1:0])
            2'b00:   w_off_eff = in_addr[1:0];
            2'b01:   w_off_eff = {in_addr[1], 1'b0};
            default: w_off_eff = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_misaligned;
    assign w_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                          ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    assign w_err = !w_legal || w_misaligned;
`else
    assign w_err = !w_legal;
`endif

    always_comb begin
        case (in_funct3[1:0])
            2'b00:   w_wmask = 4'b0001 << w_off_eff;
            2'b01:   w_wmask = 4'b0011 << w_off_eff;
            default: w_wmask = 4'b1111;
        endcase
    end

    assign w_wdata = in_wdata << {w_off_eff, 3'b000};

    // Load extraction uses the offset latched at accept time.
    assign w_ld_sh = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld = {{24{w_ld_sh[7]}},  w_ld_sh[7:0]};
            3'b001:  w_ld = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
            3'b100:  w_ld = {24'd0, w_ld_sh[7:0]};
            3'b101:  w_ld = {16'd0, w_ld_sh[15:0]};
            default: w_ld = w_ld_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 4'd0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_store     <= in_store;
                        r_funct3    <= in_funct3;
                        r_off       <= w_off_eff;
                        r_mem_we    <= in_store;
                        r_mem_addr  <= {in_addr[31:2], 2'b00};
                        r_mem_wdata <= in_store ? w_wdata : 32'd0;
                        r_mem_wmask <= in_store ? w_wmask : 4'd0;
                        r_wb_we     <= 1'b0;
                        r_wb_rd     <= in_rd;
                        r_wb_data   <= 32'd0;
                        r_wb_err    <= w_err;
                        r_state     <= w_err ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_wb_we   <= !r_store;
                        r_wb_data <= r_store ? 32'd0 : w_ld;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign wb_valid      = (r_state == S_DONE);
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;
    assign wb_we         = r_wb_we;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign wb_err        = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. A transaction-level model computes
//            the expected per-cycle handshake and the request / write-back
//            contents; a negedge process compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    lsu u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        e_in_ready, e_req_valid, e_wb_valid;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_wb_we, e_wb_err;
    logic [4:0]  e_wb_rd;
    logic [31:0] e_wb_data;

    // Observations for the directed literal checks.
    int unsigned last_wb_cyc = 0;
    logic [31:0] last_wb_data = 32'd0;
    logic        last_wb_err = 1'b0;
    logic        last_wb_we = 1'b0;
    logic [31:0] last_req_addr = 32'd0;
    logic [31:0] last_req_wdata = 32'd0;
    logic [3:0]  last_req_wmask = 4'd0;
    int unsigned t_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(e_in_ready));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(e_req_valid));
            chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
            if (e_req_valid) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                if (e_we) begin
                    chk("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
                    chk("mem_wdata", mem_wdata, e_wdata);
                end
            end
            if (e_wb_valid) begin
                chk("wb_we", 32'(wb_we), 32'(e_wb_we));
                chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
                chk("wb_data", wb_data, e_wb_data);
                chk("wb_err", 32'(wb_err), 32'(e_wb_err));
            end
            if (wb_valid) begin
                last_wb_cyc  = cyc;
                last_wb_data = wb_data;
                last_wb_err  = wb_err;
                last_wb_we   = wb_we;
            end
            if (mem_req_valid) begin
                last_req_addr  = mem_addr;
                last_req_wdata = mem_wdata;
                last_req_wmask = mem_wmask;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_phase(input logic rdy, input logic req, input logic wbv);
        e_in_ready  = rdy;
        e_req_valid = req;
        e_wb_valid  = wbv;
    endtask

    // Inputs that must be ignored while busy get random garbage.
    task automatic scramble();
        in_valid  = 1'($urandom);
        in_store  = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_rd     = 5'($urandom);
    endtask

    // Model: derives expected request and completion from the ISA rules.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, output logic err);
        logic        legal, mis;
        int          bytes, off, offe;
        logic [31:0] v, ld;
        bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        off   = int'(addr[1:0]);
        mis   = (off % bytes) != 0;
        offe  = off - (off % bytes);
`ifdef LSU_MISALIGN_CHECK_EN
        err = !legal || mis;
`else
        err = !legal;
        if (mis) err = err;
`endif
        e_addr  = addr & 32'hFFFF_FFFC;
        e_we    = st;
        e_wmask = 4'(((1 << bytes) - 1) << offe);
        e_wdata = wd << (8 * offe);
        v  = rdata >> (8 * offe);
        if (bytes == 1)      ld = f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
        else if (bytes == 2) ld = f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
        else                 ld = v;
        e_wb_rd   = rd;
        e_wb_err  = err;
        e_wb_we   = !err && !st;
        e_wb_data = (err || st) ? 32'd0 : ld;
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
        logic err;
        model(st, f3, addr, wd, rd, rdata, err);
        step();
        in_valid = 1'b1; in_store = st; in_funct3 = f3; in_addr = addr;
        in_wdata = wd; in_rd = rd;
        mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        expect_phase(1'b1, 1'b0, 1'b0);
        t_acc = cyc;
        if (!err) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                step(); scramble();
                mem_req_ready = (k == rdy_dly);
                mem_rsp_valid = 1'($urandom);
                mem_rdata     = $urandom;
                expect_phase(1'b0, 1'b1, 1'b0);
            end
            for (int k = 0; k <= rsp_dly; k++) begin
                step(); scramble();
                mem_req_ready = 1'($urandom);
                mem_rsp_valid = (k == rsp_dly);
                mem_rdata     = (k == rsp_dly) ? rdata : $urandom;
                expect_phase(1'b0, 1'b0, 1'b0);
            end
        end
        step(); scramble();
        mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        expect_phase(1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0; mem_rsp_valid = 1'($urandom);
        expect_phase(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic       st;
        rst = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
        expect_phase(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        // Reset state pinned with literals.
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_we", 32'(wb_we), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst wb_err", 32'(wb_err), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // LW, minimum latency.
        run_op(1'b0, 3'b010, 32'h8000_0004, 32'd0, 5'd7, 32'hDEAD_BEEF, 0, 0);
        chk("lw addr", last_req_addr, 32'h8000_0004);
        chk("lw data", last_wb_data, 32'hDEAD_BEEF);
        chk("lw we", 32'(last_wb_we), 32'd1);
        chk("lw latency", last_wb_cyc - t_acc, 32'd3);

        // LB / LBU sign handling.
        run_op(1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd3, 32'h80FF_1234, 0, 0);
        chk("lb data", last_wb_data, 32'hFFFF_FF80);
        run_op(1'b0, 3'b100, 32'h8000_0003, 32'd0, 5'd3, 32'h80FF_1234, 0, 0);
        chk("lbu data", last_wb_data, 32'h0000_0080);

        // SH upper lane.
        run_op(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd0, 32'd0, 0, 0);
        chk("sh wmask", 32'(last_req_wmask), 32'h0000_000C);
        chk("sh wdata", last_req_wdata, 32'hABCD_0000);
        chk("sh wb_we", 32'(last_wb_we), 32'd0);

        // Backpressure on the request.
        run_op(1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd9, 32'h1234_5678, 3, 0);
        chk("stall latency", last_wb_cyc - t_acc, 32'd6);

        // Reset while waiting for the response.
        model(1'b0, 3'b010, 32'h8000_0020, 32'd0, 5'd4, 32'd0, st);
        step(); in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h8000_0020; in_rd = 5'd4; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        expect_phase(1'b1, 1'b0, 1'b0);
        step(); in_valid = 1'b0; mem_req_ready = 1'b1;
        expect_phase(1'b0, 1'b1, 1'b0);
        step(); mem_req_ready = 1'b0;
        expect_phase(1'b0, 1'b0, 1'b0);
        step(); rst = 1'b1;
        expect_phase(1'b0, 1'b0, 1'b0);
        step(); rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        expect_phase(1'b1, 1'b0, 1'b0);
        step(); mem_rsp_valid = 1'b0;
        expect_phase(1'b1, 1'b0, 1'b0);
        chk("post-rst mem_addr", mem_addr, 32'd0);
        run_op(1'b0, 3'b010, 32'h8000_0024, 32'd0, 5'd5, 32'h0BAD_CAFE, 0, 0);
        chk("post-rst lw", last_wb_data, 32'h0BAD_CAFE);

        // Misaligned word.
        run_op(1'b0, 3'b010, 32'h8000_0002, 32'd0, 5'd6, 32'h5555_AAAA, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis lw err", 32'(last_wb_err), 32'd1);
        chk("mis lw latency", last_wb_cyc - t_acc, 32'd1);
`else
        chk("mis lw addr", last_req_addr, 32'h8000_0000);
        chk("mis lw err", 32'(last_wb_err), 32'd0);
        chk("mis lw data", last_wb_data, 32'h5555_AAAA);
`endif

        // Illegal funct3.
        run_op(1'b1, 3'b011, 32'h8000_0008, 32'h1, 5'd1, 32'd0, 0, 0);
        chk("illegal err", 32'(last_wb_err), 32'd1);
        chk("illegal latency", last_wb_cyc - t_acc, 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else    f3 = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2))
                                                           : 3'($urandom_range(4, 5));
            end
            run_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
